// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the scoreboarded register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by accepted issues, cleared by effective writebacks.
module rf_scoreboard #(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic             wr_en,
  input  logic             wr_fire,
  input  logic [AW-1:0]    wr_addr,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             issue_ack,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] one_hot_s;
  logic             zero_hit_s;
  logic             set_s;

  assign busy_vec = busy_r;

  // Acceptance of a claim and the resulting set/clear masks (a same-cycle issue wins over clear).
  always_comb begin
    one_hot_s   = {{(NREGS-1){1'b0}}, 1'b1};
    zero_hit_s  = (ZERO_REG != 0) && (issue_addr == {AW{1'b0}});
    issue_ack   = issue_en & init_done &
                  (zero_hit_s | ~busy_r[issue_addr] | (wr_en & (wr_addr == issue_addr)));
    set_s       = issue_ack & ~zero_hit_s;
    clr_mask_s  = wr_fire ? (one_hot_s << wr_addr) : {NREGS{1'b0}};
    set_mask_s  = set_s ? (one_hot_s << issue_addr) : {NREGS{1'b0}};
    busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

endmodule

// File: rtl/scoreboarded_register_file.sv
// Register file with N read ports, one write port, optional bypass/zero register,
// busy scoreboard, and a post-reset clearing sweep so storage needs no reset.
module scoreboarded_register_file
  import rf_pkg::*;
#(
  parameter int  XLEN       = XLEN_DEF,
  parameter int  NREGS      = NREGS_DEF,
  parameter int  NRD        = 2,
  parameter int  ZERO_REG   = 1,
  parameter int  BYPASS     = 1,
  parameter int  INIT_SWEEP = 1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic                issue_ack,
  output logic [NREGS-1:0]    busy_vec
);

  localparam rf_state_e  RESET_STATE = (INIT_SWEEP != 0) ? SWEEP : READY;
  localparam logic [AW:0] LAST_CNT   = (AW+1)'(NREGS - 1);

  rf_state_e        state_r, state_next_s;
  logic [AW:0]      sweep_cnt_r, sweep_cnt_next_s;
  logic [XLEN-1:0]  mem_r [NREGS];
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [XLEN-1:0]  mem_wdata_s;
  logic             wr_fire_s;
  logic [AW-1:0]    ra_s;

  assign init_done = (state_r == READY);
  assign wr_fire_s = wr_en & init_done & ~((ZERO_REG != 0) && (wr_addr == {AW{1'b0}}));

  // Sweep state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RESET_STATE;
      sweep_cnt_r <= {(AW+1){1'b0}};
    end else begin
      state_r     <= state_next_s;
      sweep_cnt_r <= sweep_cnt_next_s;
    end
  end

  // Sweep next-state: one register per cycle, READY once the last one is written.
  always_comb begin
    state_next_s     = state_r;
    sweep_cnt_next_s = sweep_cnt_r;
    case (state_r)
      SWEEP: begin
        sweep_cnt_next_s = sweep_cnt_r + (AW+1)'(1);
        if (sweep_cnt_r == LAST_CNT) begin
          state_next_s = READY;
        end else begin
          state_next_s = SWEEP;
        end
      end
      READY:   state_next_s = READY;
      default: state_next_s = RESET_STATE;
    endcase
  end

  // Storage write port shared between the clearing sweep and writeback.
  always_comb begin
    if (state_r == SWEEP) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = sweep_cnt_r[AW-1:0];
      mem_wdata_s = {XLEN{1'b0}};
    end else begin
      mem_we_s    = wr_fire_s;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end
  end

  generate
    if (INIT_SWEEP != 0) begin : g_noreset_mem
      // Reset-free storage, cleared by the sweep.
      always_ff @(posedge clk) begin
        if (mem_we_s) begin
          mem_r[mem_waddr_s] <= mem_wdata_s;
        end
      end
    end else begin : g_reset_mem
      // Storage with asynchronous clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int r = 0; r < NREGS; r++) begin
            mem_r[r] <= {XLEN{1'b0}};
          end
        end else if (mem_we_s) begin
          mem_r[mem_waddr_s] <= mem_wdata_s;
        end
      end
    end
  endgenerate

  // Read muxes; a bypassing write supplies data and masks the stale busy bit.
  always_comb begin
    rd_data = {(NRD*XLEN){1'b0}};
    rd_busy = {NRD{1'b0}};
    ra_s    = {AW{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      ra_s = rd_addr[i*AW +: AW];
      if (!init_done) begin
        rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[i]              = 1'b0;
      end else if ((BYPASS != 0) && wr_fire_s && (wr_addr == ra_s)) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
        rd_busy[i]              = 1'b0;
      end else if ((ZERO_REG != 0) && (ra_s == {AW{1'b0}})) begin
        rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[i]              = busy_vec[ra_s];
      end else begin
        rd_data[i*XLEN +: XLEN] = mem_r[ra_s];
        rd_busy[i]              = busy_vec[ra_s];
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .wr_en      (wr_en),
    .wr_fire    (wr_fire_s),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_ack  (issue_ack),
    .busy_vec   (busy_vec)
  );

endmodule
